// File: rtl/int_ctrl.sv
// int_ctrl: edge-latched, maskable, fixed-priority interrupt controller with REQ/ACK/EOI handshake
module int_ctrl #(
   parameter int NUM_SRC = 16,
   parameter int ID_W    = 4,
   parameter int DATA_W  = 16
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic [NUM_SRC-1:0] IRQ,
   input  logic               WR_EN,
   input  logic               RD_EN,
   input  logic [1:0]         ADDR,
   input  logic [DATA_W-1:0]  WDATA,
   output logic [DATA_W-1:0]  RDATA,
   output logic               INT2COR,
   output logic [ID_W-1:0]    NUM_INT,
   input  logic               INT_ACK,
   input  logic               INT_EOI
);
   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2} state_t;
   state_t state_q, state_d;
   logic [NUM_SRC-1:0] irq_q, mask_q, mask_d, pend_q, pend_d, insv_q, insv_d;
   logic [NUM_SRC-1:0] wsrc, edge_v, req, pend_clr, ack_clr;
   logic [DATA_W-1:0]  rdata_q, rdata_d;
   logic [ID_W-1:0]    num_q, num_d, win;
   logic               int2cor_q, int2cor_d, ack;
   always_comb begin
      win = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--)
         if (req[i]) win = ID_W'(i);
   end
   always_comb begin
      wsrc      = WDATA[NUM_SRC-1:0];
      edge_v    = IRQ & ~irq_q;
      req       = pend_q & mask_q;
      ack       = (state_q == REQ) && INT_ACK;
      ack_clr   = ack ? (NUM_SRC'(1) << num_q) : '0;
      mask_d    = (WR_EN && ADDR == 2'd0) ? wsrc : mask_q;
      pend_clr  = (WR_EN && ADDR == 2'd1) ? wsrc : '0;
      // a fresh edge always survives a same-cycle clear
      pend_d    = (pend_q & ~pend_clr & ~ack_clr) | edge_v;
      state_d   = state_q;
      int2cor_d = int2cor_q;
      num_d     = num_q;
      insv_d    = insv_q;
      case (state_q)
         IDLE: if (|req) begin
            num_d     = win;
            int2cor_d = 1'b1;
            state_d   = REQ;
         end
         REQ: if (ack) begin
            insv_d    = ack_clr;
            int2cor_d = 1'b0;
            state_d   = SERVICE;
         end else if (!(mask_d[num_q] && pend_d[num_q])) begin
            int2cor_d = 1'b0;
            state_d   = IDLE;
         end
         SERVICE: if (INT_EOI) begin
            insv_d  = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      rdata_d = !RD_EN ? '0 :
                ADDR == 2'd0 ? DATA_W'(mask_q) :
                ADDR == 2'd1 ? DATA_W'(pend_q) :
                ADDR == 2'd2 ? DATA_W'(insv_q) :
                DATA_W'({state_q, num_q});
   end
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q   <= IDLE;
         irq_q     <= '0;
         mask_q    <= '0;
         pend_q    <= '0;
         insv_q    <= '0;
         rdata_q   <= '0;
         num_q     <= '0;
         int2cor_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         irq_q     <= IRQ;
         mask_q    <= mask_d;
         pend_q    <= pend_d;
         insv_q    <= insv_d;
         rdata_q   <= rdata_d;
         num_q     <= num_d;
         int2cor_q <= int2cor_d;
      end
   end
   assign RDATA   = rdata_q;
   assign INT2COR = int2cor_q;
   assign NUM_INT = num_q;
endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed self-checking bench for int_ctrl
module tb_int_ctrl;
   logic        CLK = 1'b0, RESET = 1'b1, WR_EN = 1'b0, RD_EN = 1'b0;
   logic        INT_ACK = 1'b0, INT_EOI = 1'b0, INT2COR;
   logic [15:0] IRQ = '0, WDATA = '0, RDATA;
   logic [1:0]  ADDR = '0;
   logic [3:0]  NUM_INT;
   int          n_chk = 0, n_fail = 0;
   always #5 CLK = ~CLK;
   int_ctrl #(.NUM_SRC(16), .ID_W(4), .DATA_W(16)) dut (
      .CLK(CLK), .RESET(RESET), .IRQ(IRQ), .WR_EN(WR_EN), .RD_EN(RD_EN),
      .ADDR(ADDR), .WDATA(WDATA), .RDATA(RDATA), .INT2COR(INT2COR),
      .NUM_INT(NUM_INT), .INT_ACK(INT_ACK), .INT_EOI(INT_EOI)
   );
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask
   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic wr(input logic [1:0] a, input logic [15:0] v);
      WR_EN = 1'b1; ADDR = a; WDATA = v;
      tick();
      WR_EN = 1'b0; WDATA = '0;
   endtask
   task automatic rdchk(input string tag, input logic [1:0] a, input logic [15:0] exp);
      RD_EN = 1'b1; ADDR = a;
      tick();
      RD_EN = 1'b0;
      chk(tag, RDATA, exp);
   endtask
   task automatic pulse_ack(input logic eoi_too);
      INT_ACK = 1'b1; INT_EOI = eoi_too;
      tick();
      INT_ACK = 1'b0; INT_EOI = 1'b0;
   endtask
   task automatic pulse_eoi();
      INT_EOI = 1'b1;
      tick();
      INT_EOI = 1'b0;
   endtask
   initial begin
      tick(); tick();
      chk("rst_int2cor", INT2COR, 16'h0);
      chk("rst_num", NUM_INT, 16'h0);
      chk("rst_rdata", RDATA, 16'h0);
      RESET = 1'b0;
      tick();
      rdchk("rst_mask", 2'd0, 16'h0000);
      rdchk("rst_stat", 2'd3, 16'h0000);
      // 1: single source, two-cycle latency, ACK moves it to service
      wr(2'd0, 16'hFFFF);
      IRQ = 16'h0020;
      tick();
      IRQ = '0;
      chk("t1_int2cor_early", INT2COR, 16'h0);
      tick();
      chk("t1_int2cor", INT2COR, 16'h1);
      chk("t1_num", NUM_INT, 16'h5);
      rdchk("t1_stat_req", 2'd3, 16'h0015);
      pulse_ack(1'b0);
      chk("t1_int2cor_ack", INT2COR, 16'h0);
      rdchk("t1_insv", 2'd2, 16'h0020);
      rdchk("t1_pend", 2'd1, 16'h0000);
      rdchk("t1_stat_svc", 2'd3, 16'h0025);
      pulse_eoi();
      rdchk("t1_insv_eoi", 2'd2, 16'h0000);
      // 2: simultaneous edges, lowest index first, next one after EOI
      IRQ = 16'h0208;
      tick();
      IRQ = '0;
      tick();
      chk("t2_num_first", NUM_INT, 16'h3);
      pulse_ack(1'b0);
      pulse_eoi();
      chk("t2_int2cor_eoi", INT2COR, 16'h0);
      tick();
      chk("t2_int2cor_next", INT2COR, 16'h1);
      chk("t2_num_next", NUM_INT, 16'h9);
      pulse_ack(1'b0);
      pulse_eoi();
      // 3: masked pending, then unmask
      wr(2'd0, 16'h0000);
      IRQ = 16'h0004;
      tick();
      IRQ = '0;
      tick();
      rdchk("t3_pend", 2'd1, 16'h0004);
      chk("t3_no_int", INT2COR, 16'h0);
      wr(2'd2, 16'hFFFF);
      rdchk("t3_insv_ro", 2'd2, 16'h0000);
      pulse_ack(1'b0);
      rdchk("t3_ack_idle", 2'd2, 16'h0000);
      wr(2'd0, 16'h0004);
      chk("t3_int2cor_wr", INT2COR, 16'h0);
      tick();
      chk("t3_int2cor", INT2COR, 16'h1);
      chk("t3_num", NUM_INT, 16'h2);
      pulse_ack(1'b0);
      pulse_eoi();
      // edge and W1C of the same bit in one cycle: the set wins
      IRQ = 16'h0400;
      wr(2'd1, 16'h0400);
      IRQ = '0;
      rdchk("t3_set_wins", 2'd1, 16'h0400);
      wr(2'd1, 16'h0400);
      rdchk("t3_w1c", 2'd1, 16'h0000);
      // 4: W1C of the requesting source withdraws the request
      wr(2'd0, 16'hFFFF);
      IRQ = 16'h0080;
      tick();
      IRQ = '0;
      tick();
      chk("t4_num", NUM_INT, 16'h7);
      wr(2'd1, 16'h0080);
      chk("t4_int2cor", INT2COR, 16'h0);
      rdchk("t4_stat", 2'd3, 16'h0007);
      rdchk("t4_insv", 2'd2, 16'h0000);
      rdchk("t4_pend", 2'd1, 16'h0000);
      // 5: held level gives one request; ACK+EOI together takes ACK
      IRQ = 16'h0002;
      tick();
      tick();
      chk("t5_num", NUM_INT, 16'h1);
      pulse_ack(1'b1);
      rdchk("t5_insv", 2'd2, 16'h0002);
      rdchk("t5_stat", 2'd3, 16'h0021);
      rdchk("t5_pend", 2'd1, 16'h0000);
      repeat (5) tick();
      IRQ = '0;
      pulse_eoi();
      tick(); tick();
      chk("t5_one_req", INT2COR, 16'h0);
      // 6: asynchronous reset while in service
      IRQ = 16'h0010;
      tick();
      IRQ = '0;
      tick();
      pulse_ack(1'b0);
      IRQ = 16'h0040;
      tick();
      IRQ = '0;
      RD_EN = 1'b1; ADDR = 2'd2;
      tick();
      chk("t6_pre_rdata", RDATA, 16'h0010);
      #2 RESET = 1'b1;
      #1;
      chk("t6_rdata", RDATA, 16'h0);
      chk("t6_num", NUM_INT, 16'h0);
      chk("t6_int2cor", INT2COR, 16'h0);
      RD_EN = 1'b0;
      tick();
      RESET = 1'b0;
      rdchk("t6_mask", 2'd0, 16'h0000);
      rdchk("t6_pend", 2'd1, 16'h0000);
      rdchk("t6_insv", 2'd2, 16'h0000);
      rdchk("t6_stat", 2'd3, 16'h0000);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
